// File: rtl/if_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time, holds the
// fetched word for decode, and follows branch/jump redirects from execute.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_addr
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [63:0] fetch_pc;
    logic [63:0] fetch_pc_nx;
    logic [63:0] kill_pc;
    logic [63:0] kill_pc_nx;
    logic [31:0] inst_r;
    logic [31:0] inst_nx;
    logic [63:0] inst_pc_r;
    logic [63:0] inst_pc_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            kill_pc   <= '0;
            inst_r    <= NOP_INST;
            inst_pc_r <= '0;
        end else begin
            state     <= state_nx;
            fetch_pc  <= fetch_pc_nx;
            kill_pc   <= kill_pc_nx;
            inst_r    <= inst_nx;
            inst_pc_r <= inst_pc_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        kill_pc_nx  = kill_pc;
        inst_nx     = inst_r;
        inst_pc_nx  = inst_pc_r;
        case (state)
            IDLE: begin
                state_nx = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        fetch_pc_nx = redirect_pc;
                    end else begin
                        inst_nx     = imem_rdata;
                        inst_pc_nx  = fetch_pc;
                        fetch_pc_nx = fetch_pc + 64'd4;
                        state_nx    = HOLD;
                    end
                end else if (redirect_valid) begin
                    // The killed request keeps its address on the bus until its ack arrives.
                    kill_pc_nx  = fetch_pc;
                    fetch_pc_nx = redirect_pc;
                    state_nx    = DRAIN;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    fetch_pc_nx = redirect_pc;
                    state_nx    = FETCH;
                end else if (id_ready) begin
                    state_nx = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    fetch_pc_nx = redirect_pc;
                end
                if (imem_ack) begin
                    state_nx = FETCH;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req   = (state == FETCH) || (state == DRAIN);
        imem_addr  = (state == DRAIN) ? kill_pc : fetch_pc;
        inst_valid = (state == HOLD);
        inst       = (state == HOLD) ? inst_r : NOP_INST;
        inst_addr  = (state == HOLD) ? inst_pc_r : '0;
    end

endmodule
